// File: rtl/vfpu_ctrl_fsm_pkg.sv
// rtl/vfpu_ctrl_fsm_pkg.sv - job register map, streamer config and controller types
package vfpu_ctrl_fsm_pkg;

   // Job register map (32-bit words)
   localparam int A_REG_INDEX          = 0;
   localparam int B_REG_INDEX          = 4;
   localparam int R_REG_INDEX          = 8;
   localparam int TRANS_SIZE_REG_INDEX = 12;
   localparam int CTRL_REG_INDEX       = 13;

   // Bit positions inside the packed {length, stride} words
   localparam int LENGTH_MSB = 31;
   localparam int LENGTH_LSB = 16;
   localparam int STRIDE_MSB = 15;

   typedef struct packed {
      logic [31:0] base;
      logic [15:0] line_stride;
      logic [15:0] line_len;
      logic [15:0] feat_stride;
      logic [15:0] feat_len;
      logic [15:0] loop_outer;
      logic [15:0] feat_roll;
   } streamer_cfg_t;

   typedef struct packed {
      logic [2:0] operation;
      logic [1:0] rounding_mode;
   } vfpu_ctrl_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      COMPUTE = 2'd2,
      DONE    = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/vfpu_ctrl_fsm_cfg_unpack.sv
// rtl/vfpu_ctrl_fsm_cfg_unpack.sv - four job words to one streamer config
// Ports:
//   i_words  4 consecutive job words, word 0 in [31:0]
//   o_cfg    unpacked streamer configuration
module vfpu_cfg_unpack
   import vfpu_ctrl_fsm_pkg::*;
(
   input  logic [127:0]  i_words,
   output streamer_cfg_t o_cfg
);

   logic [31:0] w_word0;
   logic [31:0] w_word1;
   logic [31:0] w_word2;
   logic [31:0] w_word3;

   assign w_word0 = i_words[31:0];
   assign w_word1 = i_words[63:32];
   assign w_word2 = i_words[95:64];
   assign w_word3 = i_words[127:96];

   always_comb begin
      o_cfg             = '0;
      o_cfg.base        = w_word0;
      o_cfg.line_stride = w_word1[STRIDE_MSB:0];
      o_cfg.line_len    = w_word1[LENGTH_MSB:LENGTH_LSB];
      o_cfg.feat_stride = w_word2[STRIDE_MSB:0];
      o_cfg.feat_len    = w_word2[LENGTH_MSB:LENGTH_LSB];
      o_cfg.feat_roll   = w_word3[STRIDE_MSB:0];
      o_cfg.loop_outer  = w_word3[LENGTH_MSB:LENGTH_LSB];
   end

endmodule

// File: rtl/vfpu_ctrl_fsm.sv
// rtl/vfpu_ctrl_fsm.sv - VFPU job controller: register snapshot, streamer start, beat count, done
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   clear_i, start_i          soft clear and job trigger from the register slave
//   reg_file_i                flat job registers, word k at [32k+31:32k]
//   a/b/r_cfg_o               snapshot streamer configs
//   a/b/r_start_o             one-cycle streamer start pulses
//   r_done_i, r_beat_i        sink streamer finished / result handshake
//   vfpu_ctrl_o               snapshot {operation, rounding_mode}
//   engine_en_o, busy_o       engine enable (COMPUTE), controller busy (not IDLE)
//   done_o                    one-cycle job completion event
module vfpu_ctrl_fsm
   import vfpu_ctrl_fsm_pkg::*;
#(
   parameter int NB_REGS   = 14,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [NB_REGS*32-1:0] reg_file_i,
   output logic [127:0]         a_cfg_o,
   output logic [127:0]         b_cfg_o,
   output logic [127:0]         r_cfg_o,
   output logic                 a_start_o,
   output logic                 b_start_o,
   output logic                 r_start_o,
   input  logic                 r_done_i,
   input  logic                 r_beat_i,
   output logic [4:0]           vfpu_ctrl_o,
   output logic                 engine_en_o,
   output logic                 busy_o,
   output logic                 done_o
);

   ctrl_state_t          r_state;
   ctrl_state_t          w_state_nxt;
   streamer_cfg_t        r_a_cfg;
   streamer_cfg_t        r_b_cfg;
   streamer_cfg_t        r_r_cfg;
   streamer_cfg_t        w_a_cfg;
   streamer_cfg_t        w_b_cfg;
   streamer_cfg_t        w_r_cfg;
   vfpu_ctrl_t           r_ctrl;
   logic [CNT_WIDTH-1:0] r_size;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 r_pend;
   logic                 r_done_seen;
   logic                 w_accept;
   logic                 w_finish;
   logic [31:0]          w_ctrl_word;
   logic                 w_unused;

   vfpu_cfg_unpack u_unpack_a (
      .i_words (reg_file_i[A_REG_INDEX*32 +: 128]),
      .o_cfg   (w_a_cfg)
   );

   vfpu_cfg_unpack u_unpack_b (
      .i_words (reg_file_i[B_REG_INDEX*32 +: 128]),
      .o_cfg   (w_b_cfg)
   );

   vfpu_cfg_unpack u_unpack_r (
      .i_words (reg_file_i[R_REG_INDEX*32 +: 128]),
      .o_cfg   (w_r_cfg)
   );

   assign w_ctrl_word = reg_file_i[CTRL_REG_INDEX*32 +: 32];
   assign w_unused    = ^{w_ctrl_word[31:5], reg_file_i[TRANS_SIZE_REG_INDEX*32+CNT_WIDTH +: 32-CNT_WIDTH]};

   // The trigger is registered before the FSM acts on it, which gives the
   // two-cycle start_i-to-start-pulse latency; r_pend blocks a second accept
   // while the first one is still in flight.
   assign w_accept = (r_state == IDLE) && start_i && !r_pend && !clear_i;

   // Beat counter saturates at the programmed size.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (r_beat_i && (r_cnt != r_size)) begin
         w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
      end
   end

   // r_done_i may arrive before, with, or after the final beat.
   assign w_finish = (w_cnt_nxt == r_size) && (r_done_seen || r_done_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a_cfg <= '0;
         r_b_cfg <= '0;
         r_r_cfg <= '0;
         r_ctrl  <= '0;
         r_size  <= '0;
         r_pend  <= 1'b0;
      end else if (clear_i) begin
         r_a_cfg <= '0;
         r_b_cfg <= '0;
         r_r_cfg <= '0;
         r_ctrl  <= '0;
         r_size  <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_pend <= w_accept;
         if (w_accept) begin
            r_a_cfg              <= w_a_cfg;
            r_b_cfg              <= w_b_cfg;
            r_r_cfg              <= w_r_cfg;
            r_ctrl.operation     <= w_ctrl_word[2:0];
            r_ctrl.rounding_mode <= w_ctrl_word[4:3];
            r_size               <= reg_file_i[TRANS_SIZE_REG_INDEX*32 +: CNT_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_done_seen <= 1'b0;
      end else if (clear_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_done_seen <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && r_pend) begin
            r_cnt       <= '0;
            r_done_seen <= 1'b0;
         end else if (r_state == COMPUTE) begin
            r_cnt <= w_cnt_nxt;
            if (r_done_i) begin
               r_done_seen <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      a_start_o   = 1'b0;
      b_start_o   = 1'b0;
      r_start_o   = 1'b0;
      engine_en_o = 1'b0;
      done_o      = 1'b0;
      if (!clear_i) begin
         case (r_state)
            IDLE: begin
               if (r_pend) begin
                  w_state_nxt = (r_size == '0) ? DONE : START;
               end
            end
            START: begin
               a_start_o   = 1'b1;
               b_start_o   = 1'b1;
               r_start_o   = 1'b1;
               w_state_nxt = COMPUTE;
            end
            COMPUTE: begin
               engine_en_o = 1'b1;
               if (w_finish) begin
                  w_state_nxt = DONE;
               end
            end
            DONE: begin
               done_o      = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end else begin
         w_state_nxt = IDLE;
      end
   end

   assign busy_o      = (r_state != IDLE);
   assign a_cfg_o     = r_a_cfg;
   assign b_cfg_o     = r_b_cfg;
   assign r_cfg_o     = r_r_cfg;
   assign vfpu_ctrl_o = r_ctrl;

endmodule

// File: tb/tb_vfpu_ctrl_fsm.sv
// tb/tb_vfpu_ctrl_fsm.sv - directed self-checking bench for vfpu_ctrl_fsm
module tb_vfpu_ctrl_fsm;

   logic           clk_i;
   logic           rst_ni;
   logic           clear_i;
   logic           start_i;
   logic [447:0]   reg_file_i;
   logic [127:0]   a_cfg_o;
   logic [127:0]   b_cfg_o;
   logic [127:0]   r_cfg_o;
   logic           a_start_o;
   logic           b_start_o;
   logic           r_start_o;
   logic           r_done_i;
   logic           r_beat_i;
   logic [4:0]     vfpu_ctrl_o;
   logic           engine_en_o;
   logic           busy_o;
   logic           done_o;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   int n_en     = 0;
   int n_astart = 0;
   int snap_done;
   int snap_en;
   int snap_astart;

   vfpu_ctrl_fsm #(.NB_REGS(14), .CNT_WIDTH(16)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .start_i     (start_i),
      .reg_file_i  (reg_file_i),
      .a_cfg_o     (a_cfg_o),
      .b_cfg_o     (b_cfg_o),
      .r_cfg_o     (r_cfg_o),
      .a_start_o   (a_start_o),
      .b_start_o   (b_start_o),
      .r_start_o   (r_start_o),
      .r_done_i    (r_done_i),
      .r_beat_i    (r_beat_i),
      .vfpu_ctrl_o (vfpu_ctrl_o),
      .engine_en_o (engine_en_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (done_o)      n_done++;
      if (engine_en_o) n_en++;
      if (a_start_o)   n_astart++;
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input int k, input logic [31:0] val);
      reg_file_i[k*32 +: 32] = val;
   endtask

   // Drive start_i for one cycle and advance to the cycle where start pulses are due.
   task automatic launch;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
   endtask

   task automatic beats(input int n);
      for (int i = 0; i < n; i++) begin
         r_beat_i = 1'b1;
         tick();
      end
      r_beat_i = 1'b0;
   endtask

   localparam logic [127:0] EXP_A = {32'h1000_0000, 16'h0004, 16'h0040, 16'h0100, 16'h0008, 16'h0002, 16'h0003};
   localparam logic [127:0] EXP_B = {32'h2000_0000, 16'h0002, 16'h0010, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
   localparam logic [127:0] EXP_R = {32'h3000_0000, 16'h0006, 16'h0005, 16'h0008, 16'h0007, 16'h000A, 16'h0009};

   initial begin
      rst_ni     = 1'b0;
      clear_i    = 1'b0;
      start_i    = 1'b0;
      r_done_i   = 1'b0;
      r_beat_i   = 1'b0;
      reg_file_i = '0;
      set_reg(0,  32'h1000_0000);
      set_reg(1,  32'h0040_0004);
      set_reg(2,  32'h0008_0100);
      set_reg(3,  32'h0002_0003);
      set_reg(4,  32'h2000_0000);
      set_reg(5,  32'h0010_0002);
      set_reg(6,  32'h0000_0000);
      set_reg(7,  32'h0001_0000);
      set_reg(8,  32'h3000_0000);
      set_reg(9,  32'h0005_0006);
      set_reg(10, 32'h0007_0008);
      set_reg(11, 32'h000A_0009);
      set_reg(12, 32'd8);
      set_reg(13, 32'h0000_000B);
      tick();
      tick();

      // reset state
      chk("rst_busy", 128'(busy_o), 128'(1'b0));
      chk("rst_done", 128'(done_o), 128'(1'b0));
      chk("rst_en", 128'(engine_en_o), 128'(1'b0));
      chk("rst_acfg", a_cfg_o, 128'h0);
      chk("rst_ctrl", 128'(vfpu_ctrl_o), 128'h0);
      rst_ni = 1'b1;
      tick();

      // nominal job: size 8, operation 3, rounding 1
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("nom_start_c1", 128'(a_start_o), 128'(1'b0));
      tick();
      chk("nom_astart_c2", 128'(a_start_o), 128'(1'b1));
      chk("nom_bstart_c2", 128'(b_start_o), 128'(1'b1));
      chk("nom_rstart_c2", 128'(r_start_o), 128'(1'b1));
      chk("nom_busy", 128'(busy_o), 128'(1'b1));
      chk("nom_acfg", a_cfg_o, EXP_A);
      chk("nom_bcfg", b_cfg_o, EXP_B);
      chk("nom_rcfg", r_cfg_o, EXP_R);
      chk("nom_ctrl", 128'(vfpu_ctrl_o), 128'(5'b011_01));
      tick();
      chk("nom_start_c3", 128'(a_start_o), 128'(1'b0));
      chk("nom_en", 128'(engine_en_o), 128'(1'b1));
      beats(8);
      chk("nom_nodone_wo_rdone", 128'(done_o), 128'(1'b0));
      chk("nom_en_wait", 128'(engine_en_o), 128'(1'b1));
      snap_done = n_done;
      r_done_i = 1'b1;
      tick();
      r_done_i = 1'b0;
      chk("nom_done", 128'(done_o), 128'(1'b1));
      chk("nom_en_off", 128'(engine_en_o), 128'(1'b0));
      tick();
      chk("nom_done_1cyc", 128'(done_o), 128'(1'b0));
      chk("nom_idle", 128'(busy_o), 128'(1'b0));
      chk("nom_hold_acfg", a_cfg_o, EXP_A);
      chk("nom_done_cnt", 128'(n_done - snap_done), 128'(1));

      // zero size job
      set_reg(12, 32'd0);
      snap_en     = n_en;
      snap_astart = n_astart;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("zero_done_c1", 128'(done_o), 128'(1'b0));
      tick();
      chk("zero_done_c2", 128'(done_o), 128'(1'b1));
      tick();
      chk("zero_done_off", 128'(done_o), 128'(1'b0));
      chk("zero_idle", 128'(busy_o), 128'(1'b0));
      chk("zero_no_en", 128'(n_en - snap_en), 128'(0));
      chk("zero_no_start", 128'(n_astart - snap_astart), 128'(0));

      // r_done_i ahead of the final beat
      set_reg(12, 32'd8);
      launch();
      tick();
      for (int i = 0; i < 7; i++) begin
         r_beat_i = 1'b1;
         r_done_i = (i == 4);
         tick();
      end
      r_beat_i = 1'b0;
      r_done_i = 1'b0;
      chk("ord_nodone_7", 128'(done_o), 128'(1'b0));
      chk("ord_still_compute", 128'(engine_en_o), 128'(1'b1));
      beats(1);
      chk("ord_done", 128'(done_o), 128'(1'b1));
      tick();
      chk("ord_done_off", 128'(done_o), 128'(1'b0));

      // snapshot held, start_i ignored while busy
      snap_done   = n_done;
      snap_astart = n_astart;
      launch();
      tick();
      set_reg(0, 32'hDEAD_BEEF);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("snap_base", 128'(a_cfg_o[127:96]), 128'(32'h1000_0000));
      for (int i = 0; i < 8; i++) begin
         r_beat_i = 1'b1;
         r_done_i = (i == 7);
         tick();
      end
      r_beat_i = 1'b0;
      r_done_i = 1'b0;
      chk("snap_done", 128'(done_o), 128'(1'b1));
      tick();
      tick();
      tick();
      tick();
      chk("snap_idle", 128'(busy_o), 128'(1'b0));
      chk("snap_one_done", 128'(n_done - snap_done), 128'(1));
      chk("snap_one_start", 128'(n_astart - snap_astart), 128'(1));
      set_reg(0, 32'h1000_0000);

      // clear coinciding with final beat and r_done_i
      snap_done = n_done;
      launch();
      tick();
      beats(7);
      r_beat_i = 1'b1;
      r_done_i = 1'b1;
      clear_i  = 1'b1;
      tick();
      r_beat_i = 1'b0;
      r_done_i = 1'b0;
      clear_i  = 1'b0;
      chk("clr_done", 128'(done_o), 128'(1'b0));
      chk("clr_idle", 128'(busy_o), 128'(1'b0));
      chk("clr_en", 128'(engine_en_o), 128'(1'b0));
      chk("clr_acfg", a_cfg_o, 128'h0);
      chk("clr_ctrl", 128'(vfpu_ctrl_o), 128'h0);
      tick();
      chk("clr_no_done", 128'(n_done - snap_done), 128'(0));

      // asynchronous reset mid-COMPUTE
      launch();
      tick();
      beats(3);
      chk("rst2_pre_en", 128'(engine_en_o), 128'(1'b1));
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst2_busy", 128'(busy_o), 128'(1'b0));
      chk("rst2_en", 128'(engine_en_o), 128'(1'b0));
      chk("rst2_done", 128'(done_o), 128'(1'b0));
      chk("rst2_acfg", a_cfg_o, 128'h0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("rst2_idle", 128'(busy_o), 128'(1'b0));
      chk("rst2_idle_en", 128'(engine_en_o), 128'(1'b0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
